bcd_seg_scan: RTL

Time-multiplexed 4-digit seven-segment display driver that consumes the 16-bit packed-BCD word produced by the binary-to-decimal converter in the display path. It double-buffers the incoming BCD word, scans the four digits at a programmable rate with an anti-ghosting blank interval, and drives active-low anode and segment lines to the board display. This is the last stage before the pins.

---
 rtl/disp_pkg.sv | 27 ++
 rtl/bcd7seg.sv | 27 ++
 rtl/bcd_seg_scan.sv | 126 ++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared seven-segment display constants: active-low patterns {g,f,e,d,c,b,a},
// idle anode/segment values and the digit-index type used by the scan driver.
package disp_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [3:0] AN_OFF   = 4'hF;

  // Active-low one-cold anode pattern for a digit position.
  function automatic logic [3:0] an_select(digit_idx_t idx);
    an_select = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd7seg.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Nibbles outside 0-9 render as a dash.
module bcd7seg
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Four-digit multiplexed seven-segment driver with double-buffered BCD input
// and anti-ghosting blank interval. Optional macro: LEADING_ZERO_BLANK_EN.
module bcd_seg_scan
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] D,
  input  logic        load,
  input  logic [3:0]  dp,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        frame
);

  localparam int            PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK);

  logic [PW-1:0] pcnt;
  digit_idx_t    idx;
  logic [15:0]   pending_d;
  logic [3:0]    pending_dp;
  logic [15:0]   active_d;
  logic [3:0]    active_dp;

  logic          slot_wrap;
  logic          frame_edge;
  logic [3:0]    nib;
  logic [6:0]    seg_dec;
  logic          suppress;
  logic          blank;

  assign slot_wrap  = (pcnt == PCNT_LAST);
  assign frame_edge = slot_wrap && (idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (slot_wrap) begin
      pcnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // A load landing on the boundary edge bypasses pending so it is not lost
  // for a whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_d  <= '0;
      pending_dp <= '0;
      active_d   <= '0;
      active_dp  <= '0;
      frame      <= 1'b0;
    end else begin
      if (load) begin
        pending_d  <= D;
        pending_dp <= dp;
      end
      if (frame_edge) begin
        active_d  <= load ? D  : pending_d;
        active_dp <= load ? dp : pending_dp;
      end
      frame <= frame_edge;
    end
  end

  assign nib = active_d[{idx, 2'b00} +: 4];

  bcd7seg u_dec (
    .bcd (nib),
    .seg (seg_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] nz;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      nz[k] = |active_d[4*k +: 4];
    end
  end

  // A digit is leading-zero only if it and every more significant digit are zero.
  always_comb begin
    suppress = 1'b0;
    case (idx)
      2'd1:    suppress = ~|nz[3:1];
      2'd2:    suppress = ~|nz[3:2];
      2'd3:    suppress = ~nz[3];
      default: suppress = 1'b0;
    endcase
    if (active_dp[idx]) begin
      suppress = 1'b0;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign blank = (pcnt < BLANK_END) || suppress;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      AN  <= AN_OFF;
      SEG <= SEG_OFF;
      DP  <= 1'b1;
    end else if (blank) begin
      AN  <= AN_OFF;
      SEG <= SEG_OFF;
      DP  <= 1'b1;
    end else begin
      AN  <= an_select(idx);
      SEG <= seg_dec;
      DP  <= ~active_dp[idx];
    end
  end

endmodule
